// File: rtl/as_sdc_initiator.sv
// ---------------------------------------------------------------------------
// as_sdc_initiator
//
// Drives the autonomous-system side of the shutdown-circuit (SDC) closing
// interface. It produces a level watchdog-OK signal from the AS heartbeat.
// It issues one fixed-width close pulse per close request. It then watches
// the SDC ready and relay feedback and latches a fault when the SDC fails
// to close, or fails to stay closed.
//
// State table:
//   state      | enc | meaning
//   IDLE       |  0  | SDC open, waiting for a fresh close request
//   WAIT_READY |  1  | close requested, waiting for SDC ready and watchdog OK
//   PULSE      |  2  | as_close_sdc driven high for CLOSE_PULSE cycles
//   CONFIRM    |  3  | pulse done, waiting for relay feedback (bounded)
//   CLOSED     |  4  | SDC closed and being supervised
//   FAULT      |  5  | sticky fault, waiting for an accepted fault_clear
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   heartbeat     in   AS alive signal, rising edge = alive (async)
//   close_req     in   level close request from the AS supervisor (async)
//   open_req      in   level open request, wins over close_req (async)
//   sdc_is_ready  in   SDC logic ready (async)
//   sdc_relay_fb  in   SDC relay drive feedback (async)
//   fault_clear   in   single-cycle pulse that clears a latched fault (async)
//   watchdog      out  1 = AS alive (heartbeat edges arriving in time)
//   as_close_sdc  out  registered close pulse to the SDC latch logic
//   sdc_closed    out  1 while in CLOSED
//   fault         out  sticky fault flag (1 while in FAULT)
//   state         out  encoded FSM state for telemetry
// ---------------------------------------------------------------------------
module as_sdc_initiator #(
    parameter int HB_TIMEOUT    = 50000,
    parameter int CLOSE_PULSE   = 1000,
    parameter int READY_TIMEOUT = 100000,
    parameter int CNT_W         = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       heartbeat,
    input  logic       close_req,
    input  logic       open_req,
    input  logic       sdc_is_ready,
    input  logic       sdc_relay_fb,
    input  logic       fault_clear,
    output logic       watchdog,
    output logic       as_close_sdc,
    output logic       sdc_closed,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] HB_MAX    = CNT_W'(HB_TIMEOUT);
    localparam logic [CNT_W-1:0] PULSE_LEN = CNT_W'(CLOSE_PULSE);
    localparam logic [CNT_W-1:0] READY_LEN = CNT_W'(READY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_READY = 3'd1,
        PULSE      = 3'd2,
        CONFIRM    = 3'd3,
        CLOSED     = 3'd4,
        FAULT      = 3'd5
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizers (two flops, all async inputs)
    // -----------------------------------------------------------------------
    logic [5:0] sync_a;
    logic [5:0] sync_b;
    logic       hb_s;
    logic       close_s;
    logic       open_s;
    logic       ready_s;
    logic       relay_s;
    logic       fclr_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {heartbeat, close_req, open_req, sdc_is_ready,
                       sdc_relay_fb, fault_clear};
            sync_b <= sync_a;
        end
    end

    assign {hb_s, close_s, open_s, ready_s, relay_s, fclr_s} = sync_b;

    // -----------------------------------------------------------------------
    // Heartbeat watchdog
    // The counter saturates at HB_TIMEOUT; sitting at the limit is the trip
    // condition, and only a heartbeat edge pulls it back down. hb_seen keeps
    // watchdog low until the AS has shown at least one sign of life.
    // -----------------------------------------------------------------------
    logic             hb_d;
    logic             hb_edge;
    logic             hb_seen;
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_trip;

    assign hb_edge = hb_s & ~hb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_d    <= 1'b0;
            hb_seen <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            hb_d <= hb_s;
            if (hb_edge) begin
                hb_seen <= 1'b1;
                wd_cnt  <= '0;
            end else if (wd_cnt != HB_MAX) begin
                wd_cnt <= wd_cnt + CNT_ONE;
            end
        end
    end

    assign wd_trip  = (wd_cnt == HB_MAX);
    assign watchdog = hb_seen & ~wd_trip;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] pulse_cnt;
    logic [CNT_W-1:0] rdy_cnt;
    logic             close_armed;
    logic             enter_pulse;
    logic             acs_q;

    // Down-counter terminal counts: the transition fires on the last cycle
    // so the following state starts exactly CLOSE_PULSE / READY_TIMEOUT
    // cycles after PULSE entry.
    logic pulse_tc;
    logic rdy_tc;

    assign pulse_tc    = (pulse_cnt <= CNT_ONE);
    assign rdy_tc      = (rdy_cnt <= CNT_ONE);
    assign enter_pulse = (state_q == WAIT_READY) && (state_d == PULSE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (close_armed && close_s && !open_s && !fault) begin
                    state_d = WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (open_s || !close_s) begin
                    state_d = IDLE;
                end else if (ready_s && watchdog) begin
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (open_s) begin
                    state_d = IDLE;
                end else if (!watchdog) begin
                    state_d = FAULT;
                end else if (pulse_tc) begin
                    state_d = CONFIRM;
                end
            end
            CONFIRM: begin
                if (open_s) begin
                    state_d = IDLE;
                end else if (!watchdog) begin
                    state_d = FAULT;
                end else if (relay_s) begin
                    state_d = CLOSED;
                end else if (rdy_tc) begin
                    state_d = FAULT;
                end
            end
            CLOSED: begin
                // An intentional open wins over the supervision checks,
                // because opening naturally drops the relay feedback.
                if (open_s) begin
                    state_d = IDLE;
                end else if (!relay_s || !ready_s || !watchdog) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (fclr_s && watchdog && !close_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        fault        = 1'b0;
        sdc_closed   = 1'b0;
        as_close_sdc = acs_q;
        state        = state_q;
        case (state_q)
            CLOSED:  sdc_closed = 1'b1;
            FAULT:   fault      = 1'b1;
            default: ;
        endcase
    end

    // The close pulse is a flop that tracks the next state. It rises and
    // falls on the same edges as state_q enters and leaves PULSE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acs_q <= 1'b0;
        end else begin
            acs_q <= (state_d == PULSE);
        end
    end

    // One close attempt per request: the arm flag is cleared whenever the
    // FSM is away from IDLE. Only a low close_req observed while back in
    // IDLE re-arms it. The synchronizers reset low, which arms the flag
    // right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            close_armed <= 1'b0;
        end else if (state_q != IDLE) begin
            close_armed <= 1'b0;
        end else if (!close_s) begin
            close_armed <= 1'b1;
        end
    end

    // Pulse and ready timers both load on PULSE entry and count down,
    // saturating at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt <= '0;
            rdy_cnt   <= '0;
        end else begin
            if (enter_pulse) begin
                pulse_cnt <= PULSE_LEN;
            end else if (state_q == PULSE && pulse_cnt != CNT_ZERO) begin
                pulse_cnt <= pulse_cnt - CNT_ONE;
            end else if (state_q != PULSE) begin
                pulse_cnt <= '0;
            end

            if (enter_pulse) begin
                rdy_cnt <= READY_LEN;
            end else if ((state_q == PULSE || state_q == CONFIRM) &&
                         rdy_cnt != CNT_ZERO) begin
                rdy_cnt <= rdy_cnt - CNT_ONE;
            end else if (state_q != PULSE && state_q != CONFIRM) begin
                rdy_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_as_sdc_initiator.sv
// ---------------------------------------------------------------------------
// Testbench for as_sdc_initiator, using scaled-down timer parameters.
// It applies a table of held-input steps with expected outputs, plus
// hand-written sequences for the exact-timing corners. Those corners are
// pulse width, watchdog trip time, ready timeout, open abort, and async
// reset.
// ---------------------------------------------------------------------------
module tb_as_sdc_initiator;

    localparam int HB_TIMEOUT    = 200;
    localparam int CLOSE_PULSE   = 30;
    localparam int READY_TIMEOUT = 120;
    localparam int CNT_W         = 8;
    localparam int HB_PERIOD     = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       heartbeat = 1'b0;
    logic       close_req = 1'b0;
    logic       open_req = 1'b0;
    logic       sdc_is_ready = 1'b0;
    logic       sdc_relay_fb = 1'b0;
    logic       fault_clear = 1'b0;
    logic       watchdog;
    logic       as_close_sdc;
    logic       sdc_closed;
    logic       fault;
    logic [2:0] state;

    as_sdc_initiator #(
        .HB_TIMEOUT    (HB_TIMEOUT),
        .CLOSE_PULSE   (CLOSE_PULSE),
        .READY_TIMEOUT (READY_TIMEOUT),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .heartbeat    (heartbeat),
        .close_req    (close_req),
        .open_req     (open_req),
        .sdc_is_ready (sdc_is_ready),
        .sdc_relay_fb (sdc_relay_fb),
        .fault_clear  (fault_clear),
        .watchdog     (watchdog),
        .as_close_sdc (as_close_sdc),
        .sdc_closed   (sdc_closed),
        .fault        (fault),
        .state        (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Heartbeat source: 3-cycle high pulse every HB_PERIOD cycles while
    // enabled. hb_e0 is the clock edge that first samples the latest rise.
    bit hb_en = 1'b1;
    int hb_ph = 0;
    int hb_e0 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (hb_en) begin
                if (hb_ph == 0) begin
                    heartbeat = 1'b1;
                    hb_e0 = cyc + 1;
                end else if (hb_ph == 3) begin
                    heartbeat = 1'b0;
                end
                hb_ph = (hb_ph + 1) % HB_PERIOD;
            end else begin
                heartbeat = 1'b0;
            end
        end
    end

    function automatic logic probe(input int which);
        case (which)
            0:       return as_close_sdc;
            1:       return watchdog;
            2:       return sdc_closed;
            3:       return fault;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int which, input logic val, input int max_cyc,
                              output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (probe(which) === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_fault_clear();
        @(negedge clk);
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
    endtask

    typedef struct {
        logic       close;
        logic       open;
        logic       ready;
        logic       relay;
        logic       fclr;
        int         cycles;
        logic [2:0] st;
        logic       acs;
        logic       closed;
        logic       flt;
    } vec_t;

    localparam int NVEC = 29;
    vec_t tbl [NVEC];

    bit ok;
    int t0;
    int t1;
    bit seen;

    initial begin
        //             close open ready relay fclr cycles       st   acs  cl   flt
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5,           3'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10,          3'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5,           3'd1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5,           3'd0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5,           3'd1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5,           3'd0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5,           3'd0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5,           3'd0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5,           3'd2, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CLOSE_PULSE, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5,           3'd4, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5,           3'd5, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1,           3'd5, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5,           3'd5, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5,           3'd5, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1,           3'd5, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5,           3'd0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5,           3'd2, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CLOSE_PULSE, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5,           3'd4, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5,           3'd0, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5,           3'd0, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5,           3'd2, 1'b1, 1'b0, 1'b0};
        tbl[23] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CLOSE_PULSE, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[24] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5,           3'd4, 1'b0, 1'b1, 1'b0};
        tbl[25] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5,           3'd5, 1'b0, 1'b0, 1'b1};
        tbl[26] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5,           3'd5, 1'b0, 1'b0, 1'b1};
        tbl[27] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1,           3'd5, 1'b0, 1'b0, 1'b1};
        tbl[28] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5,           3'd0, 1'b0, 1'b0, 1'b0};

        // ---- Reset state, close_req already high, SDC ready --------------
        close_req    = 1'b1;
        sdc_is_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_watchdog", watchdog, 0);
        chk("rst_acs", as_close_sdc, 0);
        chk("rst_closed", sdc_closed, 0);
        chk("rst_fault", fault, 0);
        chk("rst_state", state, 0);
        rst_n = 1'b1;

        // ---- Close sequence: pulse width, confirm, closed -----------------
        wait_until(0, 1'b1, 300, ok);
        chk("a_pulse_seen", ok, 1);
        t0 = cyc;
        chk("a_state_pulse", state, 2);
        wait_until(0, 1'b0, CLOSE_PULSE + 10, ok);
        chk("a_pulse_end_seen", ok, 1);
        chk("a_pulse_width", cyc - t0, CLOSE_PULSE);
        chk("a_state_confirm", state, 3);
        repeat (10) @(negedge clk);
        sdc_relay_fb = 1'b1;
        t1 = cyc;
        wait_until(2, 1'b1, 20, ok);
        chk("a_closed_seen", ok, 1);
        chk("a_closed_latency", cyc - t1, 3);
        chk("a_state_closed", state, 4);
        chk("a_fault", fault, 0);
        chk("a_watchdog", watchdog, 1);

        // ---- Heartbeat lost while CLOSED ----------------------------------
        hb_en = 1'b0;
        wait_until(1, 1'b0, HB_TIMEOUT + HB_PERIOD + 20, ok);
        chk("b_wd_drop_seen", ok, 1);
        chk("b_wd_drop_time", cyc - hb_e0, HB_TIMEOUT + 2);
        @(negedge clk);
        chk("b_state_fault", state, 5);
        chk("b_fault", fault, 1);
        close_req = 1'b0;
        repeat (5) @(negedge clk);
        pulse_fault_clear();
        repeat (6) @(negedge clk);
        chk("b_clear_ignored_fault", fault, 1);
        chk("b_clear_ignored_state", state, 5);

        // Heartbeat back, then an accepted clear
        hb_en = 1'b1;
        wait_until(1, 1'b1, HB_PERIOD + 10, ok);
        chk("b_wd_back", ok, 1);
        pulse_fault_clear();
        repeat (5) @(negedge clk);
        chk("b_clear_state", state, 0);
        chk("b_clear_fault", fault, 0);

        // ---- Table of held-input steps ------------------------------------
        for (int i = 0; i < NVEC; i++) begin
            close_req    = tbl[i].close;
            open_req     = tbl[i].open;
            sdc_is_ready = tbl[i].ready;
            sdc_relay_fb = tbl[i].relay;
            fault_clear  = tbl[i].fclr;
            repeat (tbl[i].cycles) @(negedge clk);
            chk($sformatf("v%0d_state", i), state, tbl[i].st);
            chk($sformatf("v%0d_acs", i), as_close_sdc, tbl[i].acs);
            chk($sformatf("v%0d_closed", i), sdc_closed, tbl[i].closed);
            chk($sformatf("v%0d_fault", i), fault, tbl[i].flt);
            chk($sformatf("v%0d_wd", i), watchdog, 1);
        end
        fault_clear = 1'b0;

        // ---- Relay feedback never arrives: ready timeout ------------------
        sdc_relay_fb = 1'b0;
        sdc_is_ready = 1'b1;
        close_req    = 1'b1;
        wait_until(0, 1'b1, 20, ok);
        chk("c_pulse_seen", ok, 1);
        t0 = cyc;
        wait_until(3, 1'b1, READY_TIMEOUT + 20, ok);
        chk("c_timeout_seen", ok, 1);
        chk("c_timeout_time", cyc - t0, READY_TIMEOUT);
        chk("c_state_fault", state, 5);
        close_req = 1'b0;
        repeat (5) @(negedge clk);
        pulse_fault_clear();
        repeat (5) @(negedge clk);
        chk("c_clear_state", state, 0);
        chk("c_clear_fault", fault, 0);

        // ---- open_req aborts a running pulse ------------------------------
        close_req = 1'b1;
        wait_until(0, 1'b1, 20, ok);
        chk("d_pulse_seen", ok, 1);
        repeat (10) @(negedge clk);
        open_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("d_acs_before_sync", as_close_sdc, 1);
        @(negedge clk);
        chk("d_acs_dropped", as_close_sdc, 0);
        chk("d_state_idle", state, 0);
        chk("d_fault", fault, 0);
        open_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * CLOSE_PULSE + 20; i++) begin
            @(negedge clk);
            if (as_close_sdc) seen = 1'b1;
        end
        chk("d_no_second_pulse", seen, 0);
        chk("d_state_still_idle", state, 0);
        close_req = 1'b0;
        repeat (5) @(negedge clk);
        close_req = 1'b1;
        wait_until(0, 1'b1, 20, ok);
        chk("d_retoggle_pulse", ok, 1);

        // ---- Async reset during PULSE -------------------------------------
        repeat (3) @(negedge clk);
        chk("f_acs_pre", as_close_sdc, 1);
        chk("f_wd_pre", watchdog, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_acs_async", as_close_sdc, 0);
        chk("f_wd_async", watchdog, 0);
        chk("f_fault_async", fault, 0);
        chk("f_closed_async", sdc_closed, 0);
        chk("f_state_async", state, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", n_chk);
        $fatal(1);
    end

endmodule
